sar_conv_sequencer: RTL
=======================

Name: sar_conv_sequencer

Overview:
Sequences the SAR ADC digital backend on behalf of NUM_CH requesters. Picks one pending request by round-robin, steers the analog input mux, and holds the backend in load/sample for a programmable settle time. It then releases the start line, waits for end-of-conversion, and returns the code with its channel tag over a valid/ready interface. It sits between the system-side requesters and the backend's i_start/o_eoc/o_a2d pins.

Parameters:
ADC_RESOLUTION, 10, result width in bits; matches the backend.
NUM_CH, 4, number of requesters/mux inputs; must be >= 2.
SETTLE_CYCLES, 4, cycles o_start is held low after the mux switches; must be >= 1.
TIMEOUT_CYCLES, 16, maximum cycles in CONVERT before aborting; must be > ADC_RESOLUTION+1.

Ports:
i_clk  in  1  clock; all state is on the rising edge.
i_rstn  in  1  asynchronous active-low reset.
i_req  in  NUM_CH  per-channel conversion request; level, held until granted.
o_gnt  out  NUM_CH  one-hot, one-cycle pulse when a request is accepted.
o_ch_sel  out  $clog2(NUM_CH)  analog mux select.
o_start  out  1  to backend i_start; low = load/sample, high = convert.
i_eoc  in  1  backend end-of-conversion, active high.
i_a2d  in  ADC_RESOLUTION  backend result code.
o_data  out  ADC_RESOLUTION  captured result.
o_data_ch  out  $clog2(NUM_CH)  channel tag of o_data.
o_valid  out  1  result valid.
i_ready  in  1  consumer accepts the result.
o_err  out  1  qualifies o_valid: conversion timed out.
o_busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, o_gnt=0, o_ch_sel=0, o_start=0, o_data=0, o_data_ch=0, o_valid=0, o_err=0, o_busy=0, RR pointer=0. Reset mid-conversion aborts with no result delivered. o_start=0 forces the backend back into load.
- States: IDLE -> SETTLE -> CONVERT -> RESULT -> IDLE.
- IDLE:
  - o_start=0.
  - If any i_req bit is set, grant the first set bit at or after the RR pointer, wrapping at NUM_CH-1 -> 0. In the same cycle, pulse o_gnt for that bit, register o_ch_sel, set pointer = granted+1 mod NUM_CH, and go to SETTLE.
  - A request dropped before its grant is not served.
- SETTLE:
  - o_start=0 for exactly SETTLE_CYCLES cycles, counted from the cycle after the grant.
  - Then go to CONVERT and drive o_start=1 from the first CONVERT cycle.
- CONVERT:
  - o_start=1. A cycle counter starts at 1 on entry.
  - On the first cycle with i_eoc=1: o_data <= i_a2d, o_data_ch <= o_ch_sel, o_err <= 0, go to RESULT.
  - If the counter reaches TIMEOUT_CYCLES with i_eoc=0: o_data <= 0, o_err <= 1, go to RESULT.
  - If i_eoc and the timeout coincide, i_eoc wins.
- RESULT:
  - o_valid=1 and o_start=0. The backend returns to load and i_eoc falls.
  - o_data, o_data_ch and o_err stay stable until the transfer; the transfer occurs on a cycle with o_valid&i_ready.
  - After the transfer, o_valid=0 next cycle and state returns to IDLE. The earliest next grant is the cycle after IDLE is entered.
  - New requests are not granted while busy; o_gnt=0 outside IDLE.
- Latency from grant to o_valid with backend EOC at cycle N of CONVERT: 1+SETTLE_CYCLES+N cycles.
- o_ch_sel changes only on a grant, and holds its value through RESULT.

Test Plan:
- Single request: i_req=4'b0100, backend EOC at CONVERT cycle 11 with i_a2d=10'h2A5 -> o_gnt=4'b0100 for one cycle, o_ch_sel=2, o_start low 4 cycles then high. o_valid with o_data=10'h2A5, o_data_ch=2, o_err=0 at 16 cycles after grant.
- Round-robin fairness: i_req=4'b1111 held, i_ready=1 -> grant order 0,1,2,3,0. After channel 3, the next grant is channel 0.
- Backpressure: i_ready=0 for 20 cycles in RESULT -> o_valid, o_data and o_data_ch stable, no grants. On i_ready=1, one transfer, then the next grant follows.
- Timeout: i_eoc stuck 0 -> o_valid at CONVERT cycle 16 with o_err=1, o_data=0. A next conversion with normal EOC returns o_err=0.
- EOC/timeout tie: i_eoc=1 first at CONVERT cycle 16 -> o_err=0, o_data=i_a2d.
- Async reset in CONVERT: assert i_rstn=0 mid-cycle -> o_start, o_valid and o_busy go 0 immediately without a clock edge. After release with i_req=4'b0010, channel 1 is granted, since the pointer was reset to 0.

Source files
------------

// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: round-robin request arbitration, mux steering,
// settle/convert timing with timeout, and a valid/ready result port.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | backend in load, waiting for any request
// S_SETTLE  | mux switched, o_start held low while the input settles
// S_CONVERT | o_start high, waiting for i_eoc or the timeout
// S_RESULT  | o_valid high, result held until i_ready
module sar_conv_sequencer #(
  parameter int ADC_RESOLUTION = 10,
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [NUM_CH-1:0]         i_req,
  output logic [NUM_CH-1:0]         o_gnt,
  output logic [$clog2(NUM_CH)-1:0] o_ch_sel,
  output logic                      o_start,
  input  logic                      i_eoc,
  input  logic [ADC_RESOLUTION-1:0] i_a2d,
  output logic [ADC_RESOLUTION-1:0] o_data,
  output logic [$clog2(NUM_CH)-1:0] o_data_ch,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_err,
  output logic                      o_busy
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONVERT, S_RESULT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_ptr;

  logic [NUM_CH-1:0] w_rot;
  logic              w_any;
  logic [CH_W-1:0]   w_off;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [CH_W:0]     w_sum;
  logic [CH_W:0]     w_inc;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign w_rot = NUM_CH'({i_req, i_req} >> r_ptr);
  assign w_any = |i_req;

  always_comb begin
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = CH_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (CH_W+1)'(NUM_CH)) w_sum = w_sum - (CH_W+1)'(NUM_CH);
    w_idx     = w_sum[CH_W-1:0];
    w_inc     = {1'b0, w_idx} + (CH_W+1)'(1);
    w_ptr_nxt = (w_inc == (CH_W+1)'(NUM_CH)) ? '0 : w_inc[CH_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      o_gnt     <= '0;
      o_ch_sel  <= '0;
      o_start   <= 1'b0;
      o_data    <= '0;
      o_data_ch <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          o_start <= 1'b0;
          if (w_any) begin
            o_gnt    <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_idx;
            o_ch_sel <= w_idx;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= CNT_W'(SETTLE_CYCLES);
            o_busy   <= 1'b1;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Grant cycle plus SETTLE_CYCLES further cycles with o_start low.
          if (r_cnt == '0) begin
            o_start <= 1'b1;
            r_cnt   <= CNT_W'(TIMEOUT_CYCLES - 1);
            r_state <= S_CONVERT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_CONVERT: begin
          if (i_eoc) begin
            o_data    <= i_a2d;
            o_data_ch <= o_ch_sel;
            o_err     <= 1'b0;
            o_valid   <= 1'b1;
            o_start   <= 1'b0;
            r_state   <= S_RESULT;
          end else if (r_cnt == '0) begin
            o_data    <= '0;
            o_data_ch <= o_ch_sel;
            o_err     <= 1'b1;
            o_valid   <= 1'b1;
            o_start   <= 1'b0;
            r_state   <= S_RESULT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESULT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
